// File: rtl/commit_ctrl_tpu_pkg.sv
// Shared types and defaults for the TPU scalar-unit commit controller.
package pkg_tpu;

  localparam int unsigned DEPTH_BUFF = 16;

  typedef logic [$clog2(DEPTH_BUFF)-1:0] issue_no_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    ISSUED = 2'd1,
    DONE   = 2'd2
  } commit_st_t;

endpackage

// File: rtl/commit_ctrl_tpu_ptr_ctrl.sv
// Head/tail ring pointers with wrap bit, plus registered occupancy count and full/empty flags.
module commit_ptr_ctrl
  import pkg_tpu::*;
#(
  parameter  int unsigned DEPTH_BUFF = pkg_tpu::DEPTH_BUFF,
  localparam int unsigned WIDTH_BUFF = $clog2(DEPTH_BUFF)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                inc_tail,
  input  logic                inc_head,
  output logic [WIDTH_BUFF:0] head,
  output logic [WIDTH_BUFF:0] tail,
  output logic [WIDTH_BUFF:0] num,
  output logic                full,
  output logic                empty
);

  localparam int unsigned PW = WIDTH_BUFF + 1;

  logic [WIDTH_BUFF:0] head_nxt;
  logic [WIDTH_BUFF:0] tail_nxt;
  logic [WIDTH_BUFF:0] num_nxt;

  // Count is derived from the next pointers so it can never drift from them.
  always_comb begin
    head_nxt = head;
    tail_nxt = tail;
    if (inc_tail) tail_nxt = tail + PW'(1);
    if (inc_head) head_nxt = head + PW'(1);
    num_nxt = tail_nxt - head_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      num   <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      head  <= head_nxt;
      tail  <= tail_nxt;
      num   <= num_nxt;
      full  <= (num_nxt == PW'(DEPTH_BUFF));
      empty <= (num_nxt == '0);
    end
  end

endmodule

// File: rtl/commit_ctrl_tpu.sv
// In-order commit controller: tracks issued entries, accepts out-of-order completions,
// and retires the head entry once done, one per cycle.
module commit_ctrl_tpu
  import pkg_tpu::*;
#(
  parameter  int unsigned DEPTH_BUFF = pkg_tpu::DEPTH_BUFF,
  localparam int unsigned WIDTH_BUFF = $clog2(DEPTH_BUFF)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  I_Req_Issue,
  input  logic [WIDTH_BUFF-1:0] I_Issue_No,
  input  logic                  I_Done_S,
  input  logic [WIDTH_BUFF-1:0] I_Done_S_No,
  input  logic                  I_Done_V,
  input  logic [WIDTH_BUFF-1:0] I_Done_V_No,
  output logic                  O_Req_Commit,
  output logic [WIDTH_BUFF-1:0] O_Commit_No,
  output logic [WIDTH_BUFF:0]   O_Num,
  output logic                  O_Full,
  output logic                  O_Empty,
  output logic                  O_Err_Seq,
  output logic                  O_Err_Done
);

  commit_st_t st_q [DEPTH_BUFF];
  commit_st_t st_d [DEPTH_BUFF];

  logic [WIDTH_BUFF:0]   head;
  logic [WIDTH_BUFF:0]   tail;
  logic [WIDTH_BUFF-1:0] head_idx;
  logic [WIDTH_BUFF-1:0] tail_idx;
  logic                  issue_ok_c;
  logic                  commit_c;
  logic                  s_hit_c;
  logic                  v_hit_c;
  logic                  err_done_c;

  assign head_idx = head[WIDTH_BUFF-1:0];
  assign tail_idx = tail[WIDTH_BUFF-1:0];

  commit_ptr_ctrl #(.DEPTH_BUFF(DEPTH_BUFF)) u_ptr (
    .clock    (clock),
    .reset    (reset),
    .inc_tail (issue_ok_c),
    .inc_head (commit_c),
    .head     (head),
    .tail     (tail),
    .num      (O_Num),
    .full     (O_Full),
    .empty    (O_Empty)
  );

  // Full check uses the registered count, so a slot freed this edge is reusable next cycle.
  assign issue_ok_c = I_Req_Issue && !O_Full && (I_Issue_No == tail_idx);
  assign commit_c   = (st_q[head_idx] == DONE) && !O_Empty;
  assign s_hit_c    = I_Done_S && (st_q[I_Done_S_No] == ISSUED);
  assign v_hit_c    = I_Done_V && (st_q[I_Done_V_No] == ISSUED);
  assign err_done_c = (I_Done_S && (st_q[I_Done_S_No] != ISSUED))
                   || (I_Done_V && (st_q[I_Done_V_No] != ISSUED))
                   || (I_Done_S && I_Done_V && (I_Done_S_No == I_Done_V_No));

  // Issue, completion and commit always target entries in disjoint states.
  always_comb begin
    for (int i = 0; i < DEPTH_BUFF; i++) st_d[i] = st_q[i];
    if (issue_ok_c) st_d[tail_idx]    = ISSUED;
    if (s_hit_c)    st_d[I_Done_S_No] = DONE;
    if (v_hit_c)    st_d[I_Done_V_No] = DONE;
    if (commit_c)   st_d[head_idx]    = FREE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_BUFF; i++) st_q[i] <= FREE;
      O_Req_Commit <= 1'b0;
      O_Commit_No  <= '0;
      O_Err_Seq    <= 1'b0;
      O_Err_Done   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH_BUFF; i++) st_q[i] <= st_d[i];
      O_Req_Commit <= commit_c;
      if (commit_c) O_Commit_No <= head_idx;
      O_Err_Seq  <= O_Err_Seq || (I_Req_Issue && !issue_ok_c);
      O_Err_Done <= O_Err_Done || err_done_c;
    end
  end

endmodule

// File: doc/commit_ctrl_tpu.md
Name: commit_ctrl_tpu

Overview:
In-order commit controller for the TPU scalar-unit backend, directly downstream of the hazard-check/issue stage.
- Each issued instruction gets an entry in a ring of DEPTH_BUFF slots, indexed by its issue number.
- Scalar and vector execution pipes report completion out of order.
- The block retires completed entries strictly in issue order, one per cycle.
- Each retirement drives the commit request and commit number back to the hazard table so the matching entry is released.

Parameters:
DEPTH_BUFF, 16, number of in-flight entries; power of two, >= 2; equals the hazard-table ring depth.
WIDTH_BUFF, $clog2(DEPTH_BUFF), width of issue/commit numbers (derived localparam, not overridable).

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
I_Req_Issue  in  1  instruction issued this cycle
I_Issue_No  in  WIDTH_BUFF  issue number of that instruction (hazard-stage read pointer)
I_Done_S  in  1  scalar pipe completion strobe
I_Done_S_No  in  WIDTH_BUFF  issue number completed by scalar pipe
I_Done_V  in  1  vector pipe completion strobe
I_Done_V_No  in  WIDTH_BUFF  issue number completed by vector pipe
O_Req_Commit  out  1  one-cycle commit pulse to hazard stage
O_Commit_No  out  WIDTH_BUFF  issue number being committed
O_Num  out  WIDTH_BUFF+1  entries currently ISSUED or DONE
O_Full  out  1  O_Num == DEPTH_BUFF
O_Empty  out  1  O_Num == 0
O_Err_Seq  out  1  sticky: issue number not equal to expected tail, or issue while full
O_Err_Done  out  1  sticky: completion for an entry not in ISSUED

Behaviour:
- Reset (synchronous, active-high):
  - All entries FREE; head = tail = 0 (WIDTH_BUFF+1 bits, wrap bit for full/empty).
  - O_Req_Commit=0, O_Commit_No=0, O_Num=0, O_Full=0, O_Empty=1, O_Err_Seq=0, O_Err_Done=0.
  - Reset mid-operation discards all entries; no commit pulse is produced for them.
- Per-entry state (2 bits): FREE -> ISSUED (issue) -> DONE (completion) -> FREE (commit). No other transitions.
- Issue:
  - Accepted when I_Req_Issue=1, not full (pre-edge count) and I_Issue_No == tail[WIDTH_BUFF-1:0].
  - Accepted issue: entry -> ISSUED, tail++ with wrap.
  - Any other issue attempt is ignored and sets O_Err_Seq.
- Completion:
  - Each valid strobe whose target entry is ISSUED moves that entry to DONE at the next edge.
  - Strobe on a FREE or DONE entry: ignored, sets O_Err_Done.
  - Both strobes naming the same entry in one cycle: entry -> DONE, O_Err_Done set.
  - Strobes to different entries in the same cycle are both applied.
- Commit:
  - Combinational decision on registered state: head entry is DONE and count != 0.
  - At the next edge: O_Req_Commit=1 for exactly one cycle, O_Commit_No=head, entry -> FREE, head++.
  - Maximum one commit per cycle.
  - Latency from completion strobe at cycle t to O_Req_Commit high is 2 cycles (t+2) when that entry is the head.
- Simultaneous issue and commit in one cycle: O_Num unchanged.
  - When full, the issue is still rejected because the full check uses the pre-edge count.
- An issue that wraps into a slot just freed by a commit at the same edge is legal only on the following cycle. The full check enforces this.
- O_Num, O_Full and O_Empty are registered and consistent with head/tail after every edge.
- Error flags are sticky until reset.

Decomposition:
- Shared package pkg_tpu holds:
  - DEPTH_BUFF
  - the entry-state enum commit_st_t {FREE, ISSUED, DONE}
  - issue_no_t (logic [WIDTH_BUFF-1:0])
- One sub-module is natural: commit_ptr_ctrl, holding the head/tail pointers with wrap bit plus the count/full/empty logic.
- The entry state array and commit decision stay in the top module.

Test Plan:
1. Reset, then issue Nos 0,1,2 on consecutive cycles; complete 0,1,2 in order → O_Req_Commit pulses with O_Commit_No 0,1,2, each 2 cycles after its strobe; O_Num ends at 0, O_Empty=1.
2. Out-of-order completion: issue 0..3; complete 3, 2 (vector), 1, 0 (scalar) → no commit until 0 completes, then commits 0,1,2,3 on four consecutive cycles.
3. Full: DEPTH_BUFF=4; issue 0..3 → O_Full=1. Issue No 0 again → rejected, O_Err_Seq=1. Complete 0 → commit 0; after the commit, issue No 0 is accepted and O_Num returns to 4.
4. Same-cycle dual completion: issue 0,1; scalar done 0 and vector done 1 together → commit 0 then 1 in consecutive cycles, O_Err_Done=0.
5. Error cases: completion for a FREE entry 5 → O_Err_Done=1, no state change. Both strobes naming entry 2 → entry DONE, O_Err_Done=1.
6. Reset mid-stream: issue 0..2, complete 0, assert reset on the cycle a commit would be issued → no O_Req_Commit, all outputs return to reset values; issue No 0 is accepted afterwards.
